// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART line arbiter.
// UART_ARB_PREFIX_EN adds the "<id>:" prefix states to the FSM enum.
package uart_arb_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t NEWLINE    = 8'h0A;
  localparam byte_t COLON      = 8'h3A;
  localparam byte_t ASCII_ZERO = 8'h30;

`ifdef UART_ARB_PREFIX_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PFX_ID    = 2'd1,
    ST_PFX_COLON = 2'd2,
    ST_LOCKED    = 2'd3
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd3
  } arb_state_e;
`endif

  // ASCII digit for a requester index (indices stay below 10)
  function automatic byte_t id_char(input logic [3:0] id);
    return ASCII_ZERO + byte_t'(id);
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin pick: first valid index at or after rr_ptr, wrapping.
module uart_arb_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [IdxW-1:0]   index,
  output logic              any
);

  always_comb begin
    logic [IdxW:0] cand;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_ptr} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      if (!any && valid[cand[IdxW-1:0]]) begin
        any   = 1'b1;
        index = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_line_arbiter.sv
// Grants the UART transmitter to one byte-stream requester per line (newline or idle timeout).
// UART_ARB_PREFIX_EN: each granted line is preceded by "<id>:".
module uart_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned LineTimeout = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq-1:0][7:0]    req_data_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic                      tx_valid_o,
  output logic [7:0]                tx_data_o,
  input  logic                      tx_ready_i,
  output logic [$clog2(NumReq)-1:0] grant_id_o,
  output logic                      busy_o
);

  localparam int unsigned     IdxW    = $clog2(NumReq);
  localparam int unsigned     CntW    = $clog2(LineTimeout);
  localparam logic [CntW-1:0] CntLast = CntW'(LineTimeout - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] grant_d;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic            out_free;
  logic            owner_valid;
  logic            accept;
  logic            load;
  byte_t           owner_data;
  byte_t           load_data;

  uart_arb_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .valid  (req_valid_i),
    .rr_ptr (rr_ptr_q),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // Output register can take a new byte when empty or draining this cycle
  assign out_free    = !tx_valid_o || tx_ready_i;
  assign owner_valid = req_valid_i[grant_id_o];
  assign owner_data  = req_data_i[grant_id_o];
  assign accept      = (state_q == ST_LOCKED) && out_free && owner_valid;

  always_comb begin
    req_ready_o = '0;
    if ((state_q == ST_LOCKED) && out_free) begin
      req_ready_o[grant_id_o] = 1'b1;
    end
  end

  // Next-state, ownership and output-register load decisions
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_id_o;
    idle_cnt_d = idle_cnt_q;
    load       = 1'b0;
    load_data  = owner_data;
    unique case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (pick_any) begin
          grant_d = pick_idx;
`ifdef UART_ARB_PREFIX_EN
          state_d = ST_PFX_ID;
`else
          state_d = ST_LOCKED;
`endif
        end
      end
`ifdef UART_ARB_PREFIX_EN
      ST_PFX_ID: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = id_char(4'(grant_id_o));
          state_d   = ST_PFX_COLON;
        end
      end
      ST_PFX_COLON: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = COLON;
          state_d   = ST_LOCKED;
        end
      end
`endif
      ST_LOCKED: begin
        if (accept) begin
          load       = 1'b1;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CntW'(1);
        end
        // Newline and timeout in the same cycle collapse into one release
        if ((accept && (owner_data == NEWLINE)) || (idle_cnt_q == CntLast)) begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
          rr_ptr_d   = (grant_id_o == IdxLast) ? '0 : grant_id_o + IdxW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      grant_id_o <= '0;
      busy_o     <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      grant_id_o <= grant_d;
      busy_o     <= (state_d != ST_IDLE);
      if (load) begin
        tx_valid_o <= 1'b1;
        tx_data_o  <= load_data;
      end else if (tx_ready_i) begin
        tx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_line_arbiter.md
UART_LINE_ARBITER -- requirements
Module: uart_line_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of byte-stream requesters (2..10).
REQ-002 SHALL have parameter LineTimeout, default 1024, owner-idle cycles before forced release (>=2).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  NumReq  per-requester byte valid.
REQ-006 SHALL have port req_data_i  input  NumReq x 8  per-requester byte.
REQ-007 SHALL have port req_ready_o  output  NumReq  per-requester byte accept.
REQ-008 SHALL have port tx_valid_o  output  1  byte valid towards the UART transmitter.
REQ-009 SHALL have port tx_data_o  output  8  byte towards the UART transmitter.
REQ-010 SHALL have port tx_ready_i  input  1  UART transmitter accepts byte.
REQ-011 SHALL have port grant_id_o  output  $clog2(NumReq)  current/last owner index.
REQ-012 SHALL have port busy_o  output  1  high while a requester owns the line.

Function
REQ-013 SHALL implement FSM IDLE, PFX_ID, PFX_COLON, LOCKED; PFX states are reachable only with the prefix macro (REQ-028).
REQ-014 In IDLE with any req_valid_i high, SHALL select the first valid index at or after rr_ptr (wrapping), register it in grant_id_o, and enter LOCKED (or PFX_ID) next cycle.
REQ-015 req_ready_o[i] SHALL be high only in LOCKED, with i == grant_id_o, and with output register empty or tx_ready_i high; all other bits low.
REQ-016 Accepted byte (valid&ready) SHALL appear on tx_valid_o/tx_data_o the following cycle (1-cycle latency); the output register is the only storage.
REQ-017 tx_valid_o/tx_data_o SHALL stay stable until tx_ready_i is high; output register clears on handshake unless reloaded the same cycle.
REQ-018 Back-to-back bytes SHALL sustain one byte per cycle while tx_ready_i stays high.
REQ-019 Owner's accepted byte 8'h0A SHALL end the line: FSM returns to IDLE next cycle, rr_ptr := (owner+1) mod NumReq.
REQ-020 Idle counter SHALL increment each LOCKED cycle without an accepted byte, clear on accept; on reaching LineTimeout-1 the owner is released exactly as REQ-019.
REQ-021 Newline acceptance and timeout in the same cycle SHALL cause one release and one rr_ptr update.
REQ-022 Non-owner requesters SHALL never be accepted; their data is ignored.
REQ-023 Release SHALL not drop the byte held in the output register; it drains normally while a new arbitration proceeds.
REQ-024 busy_o SHALL be high in PFX_ID, PFX_COLON, LOCKED; low in IDLE.

Reset
REQ-025 On rst_i high at a clock edge: state IDLE, rr_ptr 0, idle counter 0, grant_id_o 0, busy_o 0, tx_valid_o 0, tx_data_o 8'h00, req_ready_o all 0.
REQ-026 Reset mid-line SHALL discard the held output byte and ownership without emitting further bytes.
REQ-027 Outputs SHALL hold reset values the first cycle after rst_i deasserts.

Configuration
REQ-028 Macro UART_ARB_PREFIX_EN defined: after grant, SHALL emit '0'+owner (PFX_ID) then 8'h3A ':' (PFX_COLON), each advancing only on output-register load, before LOCKED; req_ready_o low during prefix.
REQ-029 Macro undefined: IDLE SHALL go directly to LOCKED; no prefix bytes; PFX states absent from RTL.

Structure
REQ-030 Package uart_arb_pkg SHALL hold byte_t, NEWLINE (8'h0A), COLON (8'h3A), ASCII_ZERO (8'h30), and the FSM state enum.
REQ-031 Round-robin selection SHALL live in one combinational sub-module uart_arb_rr_pick (inputs valid vector, rr_ptr; outputs index, any).

Verification
REQ-032 Req1 sends "AB\n" alone, tx_ready_i=1 -> tx bytes 41,42,0A on consecutive cycles, grant_id_o=1, busy_o low after 0A.
REQ-033 Req0 and Req2 both valid from reset -> req0 line first, then req2; rr_ptr=1 then 3.
REQ-034 Req3 sends "X" then stops, LineTimeout=16 -> release 16 cycles after last accept; waiting req0 granted next.
REQ-035 tx_ready_i low 5 cycles with byte 0x41 held -> tx_data_o stays 0x41, req_ready_o all 0.
REQ-036 rst_i asserted mid-line after "AB" -> next cycle tx_valid_o=0, busy_o=0, grant_id_o=0.
REQ-037 UART_ARB_PREFIX_EN defined, req2 sends "Z\n" -> tx bytes 32,3A,5A,0A.
